// File: rtl/stack_pkg.sv
// Shared constants for the LIFO stack board: data width, capacity and the
// command FSM state encoding.
package stack_pkg;

  localparam int unsigned STACK_DW    = 4;
  localparam int unsigned STACK_DEPTH = 8;

  // Command FSM state encoding
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PUSH     = 2'd1;
  localparam logic [1:0] POP      = 2'd2;
  localparam logic [1:0] WAIT_REL = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter, debounced
// level and a single-cycle press event on each accepted 0->1 transition.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;

  // Two-stage synchroniser for the asynchronous button input
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples differing from the accepted level; flip once stable
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Stability counter, debounced level and press event registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/stack_cmd_ctrl.sv
// Front end for the board LIFO stack: turns debounced push/pop buttons into
// single-cycle strobes gated by full/empty, tracks depth and error flags.
module stack_cmd_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DW         = STACK_DW,
  parameter int unsigned DEPTH      = STACK_DEPTH,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       btn_push,
  input  logic                       btn_pop,
  input  logic [DW-1:0]              sw_data,
  input  logic                       stack_full,
  input  logic                       stack_empty,
  output logic                       stack_push,
  output logic                       stack_pop,
  output logic [DW-1:0]              stack_din,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err_overflow,
  output logic                       err_underflow
);

  localparam int unsigned DepthW = $clog2(DEPTH + 1);
  localparam logic [DepthW-1:0] DepthMax = DepthW'(DEPTH);

  logic              push_lvl, push_ev, pop_lvl, pop_ev;
  logic [1:0]        state_q, state_d;
  logic              push_q, push_d, pop_q, pop_d;
  logic [DW-1:0]     din_q, din_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_push (
    .clk     (clk),
    .rstn    (rstn),
    .btn_raw (btn_push),
    .level   (push_lvl),
    .press   (push_ev)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pop (
    .clk     (clk),
    .rstn    (rstn),
    .btn_raw (btn_pop),
    .level   (pop_lvl),
    .press   (pop_ev)
  );

  // Command FSM; strobes, depth and flags are computed on entry to PUSH/POP
  always_comb begin
    state_d = state_q;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    din_d   = din_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: begin
        if (push_ev && pop_ev) begin
          // Simultaneous requests are ambiguous: drop both silently
          state_d = WAIT_REL;
        end else if (push_ev) begin
          if (!stack_full) begin
            state_d = PUSH;
            push_d  = 1'b1;
            din_d   = sw_data;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            if (depth_q != DepthMax) depth_d = depth_q + 1'b1;
          end else begin
            ovf_d   = 1'b1;
            state_d = WAIT_REL;
          end
        end else if (pop_ev) begin
          if (!stack_empty) begin
            state_d = POP;
            pop_d   = 1'b1;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            if (depth_q != '0) depth_d = depth_q - 1'b1;
          end else begin
            unf_d   = 1'b1;
            state_d = WAIT_REL;
          end
        end
      end
      PUSH, POP: state_d = WAIT_REL;
      WAIT_REL: begin
        // Held buttons never repeat: require full release first
        if (!push_lvl && !pop_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      din_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      din_q   <= din_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign stack_push    = push_q;
  assign stack_pop     = pop_q;
  assign stack_din     = din_q;
  assign depth         = depth_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Directed bench for stack_cmd_ctrl with a short debounce window.
module tb_stack_cmd_ctrl;

  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          btn_push, btn_pop;
  logic [DW-1:0] sw_data;
  logic          stack_full, stack_empty;
  logic          stack_push, stack_pop;
  logic [DW-1:0] stack_din;
  logic [3:0]    depth;
  logic          err_overflow, err_underflow;

  int checks = 0;
  int errors = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int snap_push, snap_pop;
  logic seen;

  stack_cmd_ctrl #(.DW(DW), .DEPTH(DEPTH), .DEB_CYCLES(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .btn_push      (btn_push),
    .btn_pop       (btn_pop),
    .sw_data       (sw_data),
    .stack_full    (stack_full),
    .stack_empty   (stack_empty),
    .stack_push    (stack_push),
    .stack_pop     (stack_pop),
    .stack_din     (stack_din),
    .depth         (depth),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  // Count strobe cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (stack_push) push_cnt <= push_cnt + 1;
    if (stack_pop)  pop_cnt  <= pop_cnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; btn_push = 1'b0; btn_pop = 1'b0; sw_data = '0;
    stack_full = 1'b0; stack_empty = 1'b0;

    // 1. Reset state, then one clean push of 4'h3
    #25;
    chk("rst_push", int'(stack_push), 0);
    chk("rst_pop", int'(stack_pop), 0);
    chk("rst_din", int'(stack_din), 0);
    chk("rst_depth", int'(depth), 0);
    chk("rst_flags", int'({err_overflow, err_underflow}), 0);
    #5; @(negedge clk); rstn = 1'b1;
    cyc(3);
    sw_data = 4'h3;
    btn_push = 1'b1; cyc(20); btn_push = 1'b0; cyc(20);
    chk("t1_push_pulses", push_cnt, 1);
    chk("t1_din", int'(stack_din), 3);
    chk("t1_depth", int'(depth), 1);

    // 2. Bouncy press then steady hold: one push
    sw_data = 4'h5;
    btn_push = 1'b1; cyc(1); btn_push = 1'b0; cyc(1);
    btn_push = 1'b1; cyc(1); btn_push = 1'b0; cyc(1);
    btn_push = 1'b1; cyc(20); btn_push = 1'b0; cyc(20);
    chk("t2_push_pulses", push_cnt, 2);
    chk("t2_din", int'(stack_din), 5);
    chk("t2_depth", int'(depth), 2);

    // 3. Long pop hold: single pop, no repeat until re-press
    btn_pop = 1'b1; cyc(50);
    chk("t3_pop_held", pop_cnt, 1);
    chk("t3_depth", int'(depth), 1);
    btn_pop = 1'b0; cyc(20);
    chk("t3_pop_released", pop_cnt, 1);
    btn_pop = 1'b1; cyc(20); btn_pop = 1'b0; cyc(20);
    chk("t3_pop_repress", pop_cnt, 2);
    chk("t3_depth0", int'(depth), 0);

    // 4. Push while full: no strobe, overflow; then pop clears it, depth stays 0
    stack_full = 1'b1; sw_data = 4'hA;
    btn_push = 1'b1; cyc(20); btn_push = 1'b0; cyc(20);
    chk("t4_no_push", push_cnt, 2);
    chk("t4_ovf", int'(err_overflow), 1);
    chk("t4_din_kept", int'(stack_din), 5);
    stack_full = 1'b0;
    btn_pop = 1'b1; cyc(20); btn_pop = 1'b0; cyc(20);
    chk("t4_pop_pulses", pop_cnt, 3);
    chk("t4_ovf_cleared", int'(err_overflow), 0);
    chk("t4_depth_sat0", int'(depth), 0);

    // 5. Pop while empty: underflow; then simultaneous push+pop ignored
    stack_empty = 1'b1;
    btn_pop = 1'b1; cyc(20); btn_pop = 1'b0; cyc(20);
    chk("t5_no_pop", pop_cnt, 3);
    chk("t5_unf", int'(err_underflow), 1);
    stack_empty = 1'b0;
    btn_push = 1'b1; btn_pop = 1'b1; cyc(20);
    btn_push = 1'b0; btn_pop = 1'b0; cyc(20);
    chk("t5_both_push", push_cnt, 2);
    chk("t5_both_pop", pop_cnt, 3);
    chk("t5_flags_kept", int'({err_overflow, err_underflow}), 1);

    // 6. Reset during the push strobe cancels it; nothing after release
    sw_data = 4'h7;
    btn_push = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (stack_push) seen = 1'b1;
    end
    chk("t6_strobe_seen", int'(seen), 1);
    rstn = 1'b0; btn_push = 1'b0;
    #1;
    chk("t6_push_cancel", int'(stack_push), 0);
    chk("t6_depth_rst", int'(depth), 0);
    chk("t6_flags_rst", int'({err_overflow, err_underflow}), 0);
    snap_push = push_cnt; snap_pop = pop_cnt;
    cyc(3); rstn = 1'b1; cyc(30);
    chk("t6_no_push_after", push_cnt, snap_push);
    chk("t6_no_pop_after", pop_cnt, snap_pop);
    chk("t6_depth_after", int'(depth), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
